mem_copy_engine: RTL and testbench

- Initiator on the data memory load/store port: drives address, read enable, write enable and write data, and captures read data.
- Autonomously copies a byte block (src -> dst) or fills a block with a constant, then pulses done.
- Sits beside the core's load/store path. The memory it drives has a combinational read and a synchronous write, and tristates its read data when read enable is low.
- Also produces an 8-bit running checksum of the bytes transferred.

---
 rtl/mem_copy_engine.sv | 119 +++++++++++
 tb/tb_mem_copy_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Byte-block copy/fill engine on the data memory load/store port.
// Copies src -> dst (read then write per byte) or fills dst with a constant, keeping a mod-256 checksum.
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    input  logic          op,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW:0]   length,
    input  logic [DW-1:0] fill_val,
    input  logic [DW-1:0] MemRData,
    output logic [AW-1:0] MemAddr,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [DW-1:0] MemWData,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
    localparam logic [2:0] FILL = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]    state;
    logic [AW-1:0] src_r;
    logic [AW-1:0] dst_r;
    logic [AW:0]   len_r;
    logic [DW-1:0] fill_r;
    logic [DW-1:0] data_reg;
    logic [AW:0]   idx;
    logic [AW:0]   idx_next;

    // idx is one bit wider than the address so a 2**AW-byte block terminates cleanly.
    assign idx_next = idx + 1'b1;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= IDLE;
            src_r    <= '0;
            dst_r    <= '0;
            len_r    <= '0;
            fill_r   <= '0;
            data_reg <= '0;
            idx      <= '0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_r    <= src_addr;
                        dst_r    <= dst_addr;
                        len_r    <= length;
                        fill_r   <= fill_val;
                        idx      <= '0;
                        checksum <= '0;
                        if (length == '0)
                            state <= DONE;
                        else if (op)
                            state <= FILL;
                        else
                            state <= RD;
                    end
                end
                RD: begin
                    data_reg <= MemRData;
                    checksum <= checksum + MemRData;
                    state    <= WR;
                end
                WR: begin
                    idx   <= idx_next;
                    state <= (idx_next < len_r) ? RD : DONE;
                end
                FILL: begin
                    idx      <= idx_next;
                    checksum <= checksum + fill_r;
                    state    <= (idx_next < len_r) ? FILL : DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port is purely a function of state, so read and write can never overlap.
    always_comb begin
        MemAddr  = '0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemWData = '0;
        case (state)
            RD: begin
                MemRead = 1'b1;
                MemAddr = src_r + idx[AW-1:0];
            end
            WR: begin
                MemWrite = 1'b1;
                MemAddr  = dst_r + idx[AW-1:0];
                MemWData = data_reg;
            end
            FILL: begin
                MemWrite = 1'b1;
                MemAddr  = dst_r + idx[AW-1:0];
                MemWData = fill_r;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a behavioural memory, a reference memory image
// and a scoreboard of expected latency/checksum/access counts per transfer.
module tb_mem_copy_engine;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] src_addr = '0;
    logic [7:0] dst_addr = '0;
    logic [8:0] length = '0;
    logic [7:0] fill_val = '0;
    logic [7:0] MemRData;
    logic [7:0] MemAddr;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] MemWData;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = '0;
    logic [7:0] tb_wdata = '0;

    int n_checks = 0;
    int n_fail = 0;
    int acc_count = 0;
    int done_count = 0;
    int conflict_count = 0;
    int acc_base;
    int done_base;

    typedef struct {
        int         cycles;
        logic [7:0] csum;
        int         accesses;
    } exp_t;
    exp_t sb[$];

    mem_copy_engine #(.AW(8), .DW(8)) dut (
        .CLK(CLK), .reset(reset), .start(start), .op(op),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_val(fill_val),
        .MemRData(MemRData), .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemWData(MemWData), .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 CLK = ~CLK;

    // Combinational-read, synchronous-write memory; the bench's own port is used only for preloading.
    assign MemRData = MemRead ? mem[MemAddr] : 8'hzz;

    always @(posedge CLK) begin
        if (MemWrite)
            mem[MemAddr] <= MemWData;
        else if (tb_we)
            mem[tb_addr] <= tb_wdata;
    end

    always @(negedge CLK) begin
        if (MemRead || MemWrite) acc_count <= acc_count + 1;
        if (done) done_count <= done_count + 1;
        if (MemRead && MemWrite) conflict_count <= conflict_count + 1;
    end

    task automatic checkOutput(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", tag, act, exp);
        end
    endtask

    task automatic pokeMem(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        tb_we = 1'b1; tb_addr = a; tb_wdata = d;
        @(posedge CLK);
        #1 tb_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic checkMemImage(input string tag);
        int diffs = 0;
        for (int a = 0; a < 256; a++)
            if (mem[a] !== ref_mem[a]) diffs++;
        checkOutput(tag, diffs, 0);
    endtask

    // Drives one start pulse; when predict is set, updates the reference image and queues the expected result.
    task automatic applyStimulus(input logic o, input logic [7:0] s, input logic [7:0] d,
                                 input logic [8:0] n, input logic [7:0] f, input bit predict);
        exp_t e;
        logic [7:0] b;
        logic [7:0] cs = 8'h00;
        if (predict) begin
            for (int i = 0; i < int'(n); i++) begin
                if (o == 1'b0) begin
                    b = ref_mem[8'(int'(s) + i)];
                    ref_mem[8'(int'(d) + i)] = b;
                end else begin
                    b = f;
                    ref_mem[8'(int'(d) + i)] = f;
                end
                cs = cs + b;
            end
            e.csum = cs;
            if (n == 9'd0) begin
                e.cycles = 1; e.accesses = 0;
            end else if (o == 1'b0) begin
                e.cycles = 2 * int'(n) + 1; e.accesses = 2 * int'(n);
            end else begin
                e.cycles = int'(n) + 1; e.accesses = int'(n);
            end
            sb.push_back(e);
        end
        @(negedge CLK);
        start = 1'b1; op = o; src_addr = s; dst_addr = d; length = n; fill_val = f;
        @(posedge CLK);
        #1 start = 1'b0;
        acc_base = acc_count;
        done_base = done_count;
    endtask

    // Waits for done, checking busy every cycle; optionally pulses a competing start at cycle inj.
    task automatic waitDone(input string tag, input int inj);
        exp_t e;
        int   c = 0;
        bit   seen = 1'b0;
        for (int k = 1; k <= 600 && !seen; k++) begin
            @(negedge CLK);
            c = k;
            checkOutput({tag, "_busy"}, int'(busy), 1);
            if (done) seen = 1'b1;
            if (k == inj) begin
                start = 1'b1; op = 1'b1; src_addr = 8'h33; dst_addr = 8'h00;
                length = 9'd2; fill_val = 8'hEE;
            end
            if (k == inj + 1) start = 1'b0;
        end
        start = 1'b0;
        if (!seen) checkOutput({tag, "_timeout"}, 0, 1);
        e = sb.pop_front();
        checkOutput({tag, "_latency"}, c, e.cycles);
        checkOutput({tag, "_checksum"}, int'(checksum), int'(e.csum));
        @(negedge CLK);
        #1;
        checkOutput({tag, "_idle_busy"}, int'(busy), 0);
        checkOutput({tag, "_idle_done"}, int'(done), 0);
        checkOutput({tag, "_csum_hold"}, int'(checksum), int'(e.csum));
        checkOutput({tag, "_accesses"}, acc_count - acc_base, e.accesses);
        checkOutput({tag, "_done_pulses"}, done_count - done_base, 1);
        checkMemImage({tag, "_mem"});
    endtask

    initial begin
        $display("[TB] mem_copy_engine bench start");
        repeat (3) @(posedge CLK);
        #1 start = 1'b1;
        @(posedge CLK);
        #1 reset = 1'b0; start = 1'b0;
        @(negedge CLK);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_checksum", int'(checksum), 0);
        checkOutput("rst_mread", int'(MemRead), 0);
        checkOutput("rst_mwrite", int'(MemWrite), 0);
        checkOutput("rst_maddr", int'(MemAddr), 0);
        checkOutput("rst_mwdata", int'(MemWData), 0);

        pokeMem(8'h10, 8'h11); pokeMem(8'h11, 8'h22);
        pokeMem(8'h12, 8'h33); pokeMem(8'h13, 8'h44);
        applyStimulus(1'b0, 8'h10, 8'h80, 9'd4, 8'h00, 1'b1);
        waitDone("copy", 0);
        checkOutput("copy_byte3", int'(mem[8'h83]), 'h44);
        checkOutput("copy_csum_lit", int'(checksum), 'hAA);

        applyStimulus(1'b1, 8'h00, 8'hFE, 9'd4, 8'h5A, 1'b1);
        waitDone("fill_wrap", 0);
        checkOutput("fill_byte00", int'(mem[8'h00]), 'h5A);
        checkOutput("fill_csum_lit", int'(checksum), 'h68);

        applyStimulus(1'b0, 8'h10, 8'h20, 9'd0, 8'h00, 1'b1);
        waitDone("zero_len", 0);

        pokeMem(8'h00, 8'h01); pokeMem(8'h01, 8'h02);
        pokeMem(8'h02, 8'h03); pokeMem(8'h03, 8'h04);
        applyStimulus(1'b0, 8'h00, 8'h01, 9'd3, 8'h00, 1'b1);
        waitDone("overlap", 0);
        checkOutput("overlap_byte3", int'(mem[8'h03]), 'h01);

        applyStimulus(1'b0, 8'h10, 8'h40, 9'd4, 8'h00, 1'b1);
        waitDone("busy_start", 3);
        repeat (4) @(negedge CLK);
        #1 checkOutput("busy_start_no_restart", int'(busy), 0);
        checkOutput("busy_start_one_done", done_count - done_base, 1);
        checkMemImage("busy_start_mem_after");

        applyStimulus(1'b0, 8'h10, 8'h90, 9'd4, 8'h00, 1'b0);
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        checkOutput("midrst_mread", int'(MemRead), 0);
        checkOutput("midrst_mwrite", int'(MemWrite), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_checksum", int'(checksum), 0);
        repeat (5) @(negedge CLK);
        #1 checkOutput("midrst_no_done", done_count - done_base, 0);
        checkOutput("midrst_byte0", int'(mem[8'h90]), 'h11);
        checkOutput("midrst_byte1", int'(mem[8'h91]), 0);
        checkOutput("midrst_byte3", int'(mem[8'h93]), 0);
        ref_mem[8'h90] = 8'h11;
        checkMemImage("midrst_mem");
        applyStimulus(1'b0, 8'h10, 8'h90, 9'd4, 8'h00, 1'b1);
        waitDone("after_rst", 0);

        checkOutput("rw_conflicts", conflict_count, 0);
        checkOutput("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
